dram_rw_queue: RTL and testbench
================================

# dram_rw_queue

Parametrised DRAM request queue between the core's data-memory port and the external DRAM controller. Each accepted read or write is stored with its own address, byte enables and write data, so queued writes never share one data register. Requests issue to the controller one at a time, in order, and the core sees backpressure through a ready flag. A watchdog aborts a request the controller never acknowledges.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- ADDR_BITS, `MEM_ADDR_BITS: address width.
- DATA_BITS, `XLEN: data width; multiple of 8.
- TIMEOUT_CYCLES, 0: cycles to wait for an ack before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock; everything synchronous to its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dram_mem_addr  in  ADDR_BITS  request address.
- dram_mem_read_en  in  1  read request strobe.
- dram_mem_write_en  in  1  write request strobe.
- dram_mem_byte_enable  in  DATA_BITS/8  write byte enables.
- dram_mem_write_data  in  DATA_BITS  write data.
- dram_mem_ready  out  1  queue not full; a request is accepted only when this is high.
- dram_ack  out  1  ext_dram_ack passed through while in S_WAIT; 0 otherwise.
- dram_mem_read_data  out  DATA_BITS  ext_dram_mem_read_data passed through.
- dram_rw_pending  out  1  queue non-empty or a request outstanding.
- dram_fill_level  out  $clog2(DEPTH+1)  number of queued entries.
- dram_overflow  out  1  sticky; set when a request arrives while not ready.
- dram_timeout  out  1  one-cycle pulse when the watchdog aborts a request.
- ext_dram_mem_addr  out  ADDR_BITS  address of the issued request.
- ext_dram_mem_read_en  out  1  one-cycle issue pulse for a read.
- ext_dram_mem_write_en  out  1  one-cycle issue pulse for a write.
- ext_dram_mem_byte_enable  out  DATA_BITS/8  byte enables of the issued request.
- ext_dram_mem_write_data  out  DATA_BITS  write data of the issued request.
- ext_dram_ack  in  1  controller completion.
- ext_dram_mem_read_data  in  DATA_BITS  controller read data.

## Operation
- Push: a request is accepted when (read_en | write_en) & dram_mem_ready. If both strobes are high, the request is a write. Each entry stores {is_write, addr, be, data}.
- A request arriving while dram_mem_ready is low is dropped and sets dram_overflow, which clears only on reset.
- The FSM is one-hot: S_IDLE, S_ISSUE, S_WAIT.
  - S_IDLE: if the queue is non-empty, pop the head into the ext_* registers and go to S_ISSUE.
  - S_ISSUE: pulse ext read_en or write_en according to is_write, then go to S_WAIT.
  - S_WAIT: on ext_dram_ack, go to S_IDLE. If the watchdog expires first, pulse dram_timeout and go to S_IDLE.
- An ext_dram_ack seen outside S_WAIT is ignored and not forwarded to dram_ack.
- The watchdog counter is cleared on entry to S_WAIT and expires when it reaches TIMEOUT_CYCLES.
- The ext_* address, data and byte enables hold their values from issue until the next pop.
- dram_rw_pending = (fill ≠ 0) | (state ≠ S_IDLE).
- Push and pop in the same cycle: fill level is unchanged. This is legal even when full, but dram_mem_ready is a registered !full, so the push is refused that cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Fill level is a separate counter, so full and empty are unambiguous.

## Timing
- Reset values: all outputs 0 except dram_mem_ready = 1; state S_IDLE; pointers and fill 0.
- Reset asserted mid-transaction drops the queue and any outstanding request; no ack is forwarded afterwards.
- A request accepted at edge T is issued with ext_*_en high during cycle T+2, for exactly one cycle. ext_dram_ack is honoured from T+3 onward.
- An ack in cycle A allows the next issue pulse at A+2 at the earliest, giving a back-to-back throughput of one request per 3 cycles plus controller latency.
- dram_fill_level and dram_mem_ready update one cycle after the push or pop edge.
- With TIMEOUT_CYCLES = N, dram_timeout pulses N cycles after the first S_WAIT cycle if no ack has arrived.

## Structure
- Shared header `dram_defs.vh` holds:
  - the entry field offsets (IS_WRITE bit, ADDR, BE and DATA slices) and the entry width;
  - the one-hot state indices S_IDLE, S_ISSUE, S_WAIT.
- Sub-module `dram_cmd_fifo`: synchronous FIFO parametrised by DEPTH and WIDTH, with push, pop, head data, full, empty and level.
- The FSM, the ext_* output registers and the watchdog live in the top module.

## Test plan
- Single write at addr 0x100, data 0xDEADBEEF, be 4'hF: ext_dram_mem_write_en high exactly in cycle T+2 with those values; ack in T+5 → dram_ack in T+5, pending drops in T+6.
- Four writes back-to-back with data 1..4 (DEPTH=4), acks 3 cycles after each issue pulse: ext_dram_mem_write_data seen in order 1,2,3,4; no data corruption.
- Fill to DEPTH and attempt a fifth push: dram_mem_ready is 0, the request is dropped, dram_overflow is set and sticky, fill stays 4.
- A push and a pop in the same cycle at fill=2: fill stays 2; pointers wrap past DEPTH-1 with correct order.
- TIMEOUT_CYCLES=8 and no ack: dram_timeout pulses 8 cycles into S_WAIT, the next entry then issues, and a late ack in S_IDLE is not forwarded.
- Assert reset_n with 3 entries queued and one outstanding: all outputs return to reset values immediately; after release, pending=0 and a new request issues at T+2.

Source files
------------

// File: rtl/dram_rw_queue_pkg.sv
// Shared definitions for the DRAM request queue: one-hot FSM encoding and
// helpers that locate the fields inside a packed queue entry {is_write, addr, be, data}.
package dram_rw_queue_pkg;

  localparam int MEM_ADDR_BITS = 32;
  localparam int XLEN          = 32;

  localparam int S_IDLE_IDX  = 0;
  localparam int S_ISSUE_IDX = 1;
  localparam int S_WAIT_IDX  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ISSUE = 3'b010,
    S_WAIT  = 3'b100
  } state_t;

  // Data sits in the low bits, then byte enables, address, and the write flag on top.
  function automatic int entry_width(input int addr_bits, input int data_bits);
    return 1 + addr_bits + data_bits / 8 + data_bits;
  endfunction

  function automatic int be_lsb(input int data_bits);
    return data_bits;
  endfunction

  function automatic int addr_lsb(input int data_bits);
    return data_bits + data_bits / 8;
  endfunction

  function automatic int is_write_bit(input int addr_bits, input int data_bits);
    return data_bits + data_bits / 8 + addr_bits;
  endfunction

endpackage

// File: rtl/dram_cmd_fifo.sv
// Synchronous FIFO holding complete request entries; the fill level is a
// separate counter so full and empty never alias.
module dram_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (level_reg == LVL_W'(DEPTH));
  assign empty     = (level_reg == '0);
  assign level     = level_reg;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr_reg];

  // Storage is not reset; only written slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/dram_rw_queue.sv
// In-order DRAM request queue: buffers core reads/writes, issues them one at a
// time to the external controller, and aborts requests the controller never acks.
module dram_rw_queue
  import dram_rw_queue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_BITS      = MEM_ADDR_BITS,
  parameter int DATA_BITS      = XLEN,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_BITS-1:0]       dram_mem_addr,
  input  logic                       dram_mem_read_en,
  input  logic                       dram_mem_write_en,
  input  logic [DATA_BITS/8-1:0]     dram_mem_byte_enable,
  input  logic [DATA_BITS-1:0]       dram_mem_write_data,
  output logic                       dram_mem_ready,
  output logic                       dram_ack,
  output logic [DATA_BITS-1:0]       dram_mem_read_data,
  output logic                       dram_rw_pending,
  output logic [$clog2(DEPTH+1)-1:0] dram_fill_level,
  output logic                       dram_overflow,
  output logic                       dram_timeout,
  output logic [ADDR_BITS-1:0]       ext_dram_mem_addr,
  output logic                       ext_dram_mem_read_en,
  output logic                       ext_dram_mem_write_en,
  output logic [DATA_BITS/8-1:0]     ext_dram_mem_byte_enable,
  output logic [DATA_BITS-1:0]       ext_dram_mem_write_data,
  input  logic                       ext_dram_ack,
  input  logic [DATA_BITS-1:0]       ext_dram_mem_read_data
);

  localparam int BE_BITS  = DATA_BITS / 8;
  localparam int ENTRY_W  = entry_width(ADDR_BITS, DATA_BITS);
  localparam int BE_LSB   = be_lsb(DATA_BITS);
  localparam int ADDR_LSB = addr_lsb(DATA_BITS);
  localparam int WR_BIT   = is_write_bit(ADDR_BITS, DATA_BITS);
  localparam int LVL_W    = $clog2(DEPTH + 1);
  localparam int TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t               state_reg, state_next;
  logic                 req;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic                 is_write_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [BE_BITS-1:0]   be_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 overflow_reg;
  logic [TMO_W-1:0]     tmo_cnt_reg;
  logic                 ack_seen;
  logic                 tmo_hit;

  assign req        = dram_mem_read_en | dram_mem_write_en;
  assign push       = req & dram_mem_ready;
  // Write wins when both strobes are raised together.
  assign push_entry = {dram_mem_write_en, dram_mem_addr, dram_mem_byte_enable, dram_mem_write_data};

  dram_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ack_seen = state_reg[S_WAIT_IDX] & ext_dram_ack;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && state_reg[S_WAIT_IDX] && !ext_dram_ack
                    && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (ack_seen || tmo_hit) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      be_reg       <= '0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        is_write_reg <= head_entry[WR_BIT];
        addr_reg     <= head_entry[ADDR_LSB +: ADDR_BITS];
        be_reg       <= head_entry[BE_LSB +: BE_BITS];
        data_reg     <= head_entry[0 +: DATA_BITS];
      end
      if (req && !dram_mem_ready) overflow_reg <= 1'b1;
      // Counter restarts each time a request enters S_WAIT.
      if (state_reg[S_ISSUE_IDX]) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg[S_WAIT_IDX] && tmo_cnt_reg != TMO_W'(TIMEOUT_CYCLES)) begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end
    end
  end

  assign dram_mem_ready           = ~fifo_full;
  assign dram_fill_level          = fifo_level;
  assign dram_ack                 = ack_seen;
  assign dram_mem_read_data       = ext_dram_mem_read_data;
  assign dram_rw_pending          = (fifo_level != '0) | ~state_reg[S_IDLE_IDX];
  assign dram_overflow            = overflow_reg;
  assign dram_timeout             = tmo_hit;
  assign ext_dram_mem_addr        = addr_reg;
  assign ext_dram_mem_byte_enable = be_reg;
  assign ext_dram_mem_write_data  = data_reg;
  assign ext_dram_mem_write_en    = state_reg[S_ISSUE_IDX] & is_write_reg;
  assign ext_dram_mem_read_en     = state_reg[S_ISSUE_IDX] & ~is_write_reg;

endmodule

// File: tb/tb_dram_rw_queue.sv
// Directed bench for dram_rw_queue: a per-cycle vector table for single
// transactions plus hand-timed sequences for back-to-back, overflow, timeout and reset.
module tb_dram_rw_queue;

  logic        clk;
  logic        reset_n;
  logic [31:0] dram_mem_addr;
  logic        dram_mem_read_en;
  logic        dram_mem_write_en;
  logic [3:0]  dram_mem_byte_enable;
  logic [31:0] dram_mem_write_data;
  logic        dram_mem_ready;
  logic        dram_ack;
  logic [31:0] dram_mem_read_data;
  logic        dram_rw_pending;
  logic [2:0]  dram_fill_level;
  logic        dram_overflow;
  logic        dram_timeout;
  logic [31:0] ext_dram_mem_addr;
  logic        ext_dram_mem_read_en;
  logic        ext_dram_mem_write_en;
  logic [3:0]  ext_dram_mem_byte_enable;
  logic [31:0] ext_dram_mem_write_data;
  logic        ext_dram_ack;
  logic [31:0] ext_dram_mem_read_data;

  int checks = 0;
  int errors = 0;

  dram_rw_queue #(
    .DEPTH          (4),
    .ADDR_BITS      (32),
    .DATA_BITS      (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .dram_mem_addr            (dram_mem_addr),
    .dram_mem_read_en         (dram_mem_read_en),
    .dram_mem_write_en        (dram_mem_write_en),
    .dram_mem_byte_enable     (dram_mem_byte_enable),
    .dram_mem_write_data      (dram_mem_write_data),
    .dram_mem_ready           (dram_mem_ready),
    .dram_ack                 (dram_ack),
    .dram_mem_read_data       (dram_mem_read_data),
    .dram_rw_pending          (dram_rw_pending),
    .dram_fill_level          (dram_fill_level),
    .dram_overflow            (dram_overflow),
    .dram_timeout             (dram_timeout),
    .ext_dram_mem_addr        (ext_dram_mem_addr),
    .ext_dram_mem_read_en     (ext_dram_mem_read_en),
    .ext_dram_mem_write_en    (ext_dram_mem_write_en),
    .ext_dram_mem_byte_enable (ext_dram_mem_byte_enable),
    .ext_dram_mem_write_data  (ext_dram_mem_write_data),
    .ext_dram_ack             (ext_dram_ack),
    .ext_dram_mem_read_data   (ext_dram_mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_wen;
    logic        e_ren;
    logic        e_ack;
    logic        e_pend;
    logic [2:0]  e_fill;
    logic        chk_ext;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    dram_mem_addr          = '0;
    dram_mem_read_en       = 1'b0;
    dram_mem_write_en      = 1'b0;
    dram_mem_byte_enable   = '0;
    dram_mem_write_data    = '0;
    ext_dram_ack           = 1'b0;
    ext_dram_mem_read_data = '0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    dram_mem_write_en    = 1'b1;
    dram_mem_addr        = a;
    dram_mem_write_data  = d;
    dram_mem_byte_enable = 4'hF;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    dram_mem_ready, 1);
    check({tag, "_ack"},      dram_ack, 0);
    check({tag, "_pending"},  dram_rw_pending, 0);
    check({tag, "_fill"},     dram_fill_level, 0);
    check({tag, "_overflow"}, dram_overflow, 0);
    check({tag, "_timeout"},  dram_timeout, 0);
    check({tag, "_ext_addr"}, ext_dram_mem_addr, 0);
    check({tag, "_ext_en"},   {ext_dram_mem_read_en, ext_dram_mem_write_en}, 0);
    check({tag, "_ext_be"},   ext_dram_mem_byte_enable, 0);
    check({tag, "_ext_data"}, ext_dram_mem_write_data, 0);
  endtask

  task automatic set_row(input int i, input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic ack,
                         input logic [31:0] rdata, input logic e_wen, input logic e_ren,
                         input logic e_ack, input logic e_pend, input logic [2:0] e_fill,
                         input logic chk_ext, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic [3:0] e_be);
    tbl[i].wr = wr; tbl[i].rd = rd; tbl[i].addr = addr; tbl[i].data = data; tbl[i].be = be;
    tbl[i].ack = ack; tbl[i].rdata = rdata; tbl[i].e_ready = 1'b1; tbl[i].e_wen = e_wen;
    tbl[i].e_ren = e_ren; tbl[i].e_ack = e_ack; tbl[i].e_pend = e_pend; tbl[i].e_fill = e_fill;
    tbl[i].chk_ext = chk_ext; tbl[i].e_addr = e_addr; tbl[i].e_data = e_data; tbl[i].e_be = e_be;
  endtask

  // Row i is cycle T+i, where the write is presented in cycle T.
  task automatic apply_table(input string tag);
    for (int i = 0; i < 13; i++) begin
      next();
      drive_idle();
      dram_mem_write_en      = tbl[i].wr;
      dram_mem_read_en       = tbl[i].rd;
      dram_mem_addr          = tbl[i].addr;
      dram_mem_write_data    = tbl[i].data;
      dram_mem_byte_enable   = tbl[i].be;
      ext_dram_ack           = tbl[i].ack;
      ext_dram_mem_read_data = tbl[i].rdata;
      #3;
      check($sformatf("%s_r%0d_ready", tag, i),   dram_mem_ready, tbl[i].e_ready);
      check($sformatf("%s_r%0d_wen", tag, i),     ext_dram_mem_write_en, tbl[i].e_wen);
      check($sformatf("%s_r%0d_ren", tag, i),     ext_dram_mem_read_en, tbl[i].e_ren);
      check($sformatf("%s_r%0d_ack", tag, i),     dram_ack, tbl[i].e_ack);
      check($sformatf("%s_r%0d_pending", tag, i), dram_rw_pending, tbl[i].e_pend);
      check($sformatf("%s_r%0d_fill", tag, i),    dram_fill_level, tbl[i].e_fill);
      check($sformatf("%s_r%0d_rdata", tag, i),   dram_mem_read_data, tbl[i].rdata);
      if (tbl[i].chk_ext) begin
        check($sformatf("%s_r%0d_ext_addr", tag, i), ext_dram_mem_addr, tbl[i].e_addr);
        check($sformatf("%s_r%0d_ext_data", tag, i), ext_dram_mem_write_data, tbl[i].e_data);
        check($sformatf("%s_r%0d_ext_be", tag, i),   ext_dram_mem_byte_enable, tbl[i].e_be);
      end
      $display("%s row %0d: wen=%0b ren=%0b ack=%0b pend=%0b fill=%0d", tag, i,
               ext_dram_mem_write_en, ext_dram_mem_read_en, dram_ack, dram_rw_pending, dram_fill_level);
    end
  endtask

  initial begin
    int exp_q[$];
    int exp_c[$];
    int issue_c;
    int n_issue;
    logic armed;

    //        i  wr rd addr         data          be    ack rdata         wen ren ack pnd fill chk e_addr       e_data        e_be
    set_row(0,  1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0, 0, 0, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(1,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 1, 3'd1, 0, 32'h0,   32'h0,        4'h0);
    set_row(2,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 0, 0, 1, 3'd0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    set_row(3,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 1, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(4,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 1, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(5,  0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h0,        0, 0, 1, 1, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(6,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 0, 3'd0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    set_row(7,  0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h0,        0, 0, 0, 0, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(8,  0, 1, 32'h104, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 0, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(9,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 1, 3'd1, 0, 32'h0,   32'h0,        4'h0);
    set_row(10, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 1, 0, 1, 3'd0, 1, 32'h104, 32'h0,        4'h0);
    set_row(11, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 0, 1, 1, 3'd0, 0, 32'h0,   32'h0,        4'h0);
    set_row(12, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 0, 3'd0, 0, 32'h0,   32'h0,        4'h0);

    reset_n = 1'b0;
    drive_idle();
    #12;
    check_reset_outputs("por");
    #1;
    reset_n = 1'b1;

    apply_table("single");

    // Four writes back to back, acked three cycles after each issue pulse.
    exp_q = '{1, 2, 3, 4};
    armed = 1'b0;
    issue_c = -100;
    n_issue = 0;
    for (int c = 0; c < 35; c++) begin
      next();
      drive_idle();
      if (c < 4) push_write(32'h300 + c, c + 1);
      ext_dram_ack = armed && (c == issue_c + 3);
      if (ext_dram_ack) armed = 1'b0;
      #3;
      if (ext_dram_mem_write_en) begin
        $display("b2b issue: cycle=%0d data=%0d", c, ext_dram_mem_write_data);
        if (n_issue == 0) check("b2b_first_issue_cycle", c, 2);
        else check("b2b_issue_spacing", c - issue_c, 5);
        if (exp_q.size() > 0) check("b2b_order", ext_dram_mem_write_data, exp_q.pop_front());
        else check("b2b_extra_issue", 1, 0);
        issue_c = c;
        armed = 1'b1;
        n_issue++;
      end
    end
    check("b2b_issue_count", n_issue, 4);
    check("b2b_pending_end", dram_rw_pending, 0);

    // Fill past DEPTH with the first request unacked, let the watchdog fire,
    // then drain while a push lands on a pop at fill=2 and the pointers wrap.
    exp_q = '{1, 2, 3, 4, 5, 6};
    exp_c = '{2, 13, 18, 23, 28, 33};
    armed = 1'b0;
    issue_c = -100;
    n_issue = 0;
    for (int c = 0; c < 41; c++) begin
      next();
      drive_idle();
      if (c < 5) push_write(32'h200 + c, c + 1);
      if (c == 5) push_write(32'h2FF, 32'hBAD);
      if (c == 22) push_write(32'h222, 6);
      ext_dram_ack = (c == 12) || (armed && (c == issue_c + 3));
      if (ext_dram_ack) armed = 1'b0;
      #3;
      if (ext_dram_mem_write_en) begin
        $display("ovf issue: cycle=%0d data=%0d addr=0x%0h", c, ext_dram_mem_write_data, ext_dram_mem_addr);
        if (exp_q.size() > 0) begin
          check("ovf_order", ext_dram_mem_write_data, exp_q.pop_front());
          check("ovf_issue_cycle", c, exp_c.pop_front());
        end else begin
          check("ovf_extra_issue", 1, 0);
        end
        issue_c = c;
        armed = (ext_dram_mem_write_data != 1);
        n_issue++;
      end
      if (c == 4)  check("ovf_ready_before_full", dram_mem_ready, 1);
      if (c == 5)  begin check("ovf_ready_full", dram_mem_ready, 0); check("ovf_fill_full", dram_fill_level, 4); end
      if (c == 5)  check("ovf_flag_before", dram_overflow, 0);
      if (c == 6)  begin check("ovf_flag_set", dram_overflow, 1); check("ovf_fill_after_drop", dram_fill_level, 4); end
      if (c >= 3 && c <= 12) check($sformatf("tmo_pulse_c%0d", c), dram_timeout, c == 11);
      if (c == 12) begin check("late_ack_ignored", dram_ack, 0); check("late_ack_fill", dram_fill_level, 4); end
      if (c == 22) check("pushpop_fill_before", dram_fill_level, 2);
      if (c == 23) check("pushpop_fill_after", dram_fill_level, 2);
      if (c == 40) begin check("ovf_sticky", dram_overflow, 1); check("ovf_pending_end", dram_rw_pending, 0); end
    end
    check("ovf_issue_count", n_issue, 6);

    // Reset with three entries queued and one outstanding.
    for (int c = 0; c < 6; c++) begin
      next();
      drive_idle();
      if (c < 4) push_write(32'h400 + c, 32'h10 + c);
      if (c == 5) begin
        reset_n = 1'b0;
        ext_dram_ack = 1'b1;
      end
      #3;
      if (c == 4) begin
        check("rst_pre_fill", dram_fill_level, 3);
        check("rst_pre_pending", dram_rw_pending, 1);
      end
      if (c == 5) check_reset_outputs("midrst");
      $display("reset seq cycle %0d: fill=%0d pend=%0b", c, dram_fill_level, dram_rw_pending);
    end
    reset_n = 1'b1;
    next();
    drive_idle();
    ext_dram_ack = 1'b1;
    #3;
    check("post_rst_pending", dram_rw_pending, 0);
    check("post_rst_ack", dram_ack, 0);
    check("post_rst_wen", ext_dram_mem_write_en, 0);

    apply_table("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
